// File: rtl/dma_burst_reader_pkg.sv
// Shared definitions for the DMA burst reader: FSM state encoding, burst
// geometry and the lane layout of the 128-to-32 width converter.
package dma_burst_reader_pkg;

    // Controller states. CHECK waits for FIFO credit, REQ holds the Avalon
    // read until it is accepted, and DRAIN waits for the stream to empty.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_REQ   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Every request is a fixed 8-beat burst of 128-bit beats (0x80 bytes).
    localparam int BURST_BEATS = 8;
    localparam int BURST_BYTES = 'h80;

    // The outbound stream is 32 bits wide, giving four lanes per beat.
    localparam int LANE_W = 32;
    localparam int BEAT_W = 128;
    localparam int LANES  = BEAT_W / LANE_W;

    localparam logic [5:0] BURSTCOUNT = 6'(BURST_BEATS);

    // Lane 0 is the least significant word and leaves first.
    function automatic logic [LANE_W-1:0] lane_select(input logic [BEAT_W-1:0] beat,
                                                      input logic [1:0]        lane);
        logic [LANE_W-1:0] word;
        case (lane)
            2'd0:    word = beat[31:0];
            2'd1:    word = beat[63:32];
            2'd2:    word = beat[95:64];
            default: word = beat[127:96];
        endcase
        return word;
    endfunction

endpackage

// File: rtl/dma_burst_reader_sync_fifo_sa.sv
// Single-clock show-ahead FIFO holding read beats between the Avalon master
// and the width converter. The head word is visible on rd_data whenever the
// FIFO is non-empty; rd_en retires it.
module sync_fifo_sa #(
    parameter int W    = 128,
    parameter int LOG2 = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic [LOG2:0] used
);

    localparam int DEPTH = 1 << LOG2;
    localparam int PW    = LOG2 + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          full;
    logic          do_wr;
    logic          do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign used    = wr_ptr_q - rd_ptr_q;
    assign empty   = (used == '0);
    assign full    = used[LOG2];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_q[LOG2-1:0]];

    // Storage array; contents are don't-care while the slot is unused.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[LOG2-1:0]] <= wr_data;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // The upstream credit scheme must never let a beat arrive while full.
    wr_while_full_a: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/dma_burst_reader.sv
// DMA burst reader: issues fixed 8-beat Avalon bursts from a start address,
// buffers the returned 128-bit beats in a FIFO and streams them out as
// 32-bit words, lane 0 first. Bursts are only requested when the FIFO has
// room for every beat already in flight plus the new burst, so the sink may
// stall indefinitely without loss.
//
// Stream handshake: a word moves on q when qv & q_ready are both high in the
// same cycle. qv is high whenever a word is available and, once high, qv and
// q hold their values until that word moves; q_ready may be low for any
// number of cycles.
module dma_burst_reader
    import dma_burst_reader_pkg::*;
#(
    parameter int AW    = 23,
    parameter int FLOG2 = 5
) (
    input  logic          c,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [15:0]   num_bursts,
    output logic          busy,
    output logic          done,
    output logic          txm_read,
    output logic [AW-1:0] txm_address,
    output logic [5:0]    txm_burstcount,
    input  logic          txm_waitrequest,
    input  logic [127:0]  txm_readdata,
    input  logic          txm_readdatavalid,
    output logic [31:0]   q,
    output logic          qv,
    input  logic          q_ready
);

    localparam int DEPTH = 1 << FLOG2;
    localparam int OW    = FLOG2 + 1;   // outstanding beats never exceed DEPTH
    localparam int CW    = FLOG2 + 2;   // room for fifo_used + outstanding

    // Controller registers.
    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   remaining_q;
    logic [OW-1:0] outstanding_q;
    logic [OW-1:0] outstanding_d;
    logic          busy_q;
    logic          done_q;
    logic          read_q;

    // FIFO and converter signals.
    logic [127:0]   fifo_rdata;
    logic           fifo_empty;
    logic [FLOG2:0] fifo_used;
    logic           fifo_wr;
    logic           fifo_rd;
    logic [1:0]     lane_q;
    logic           word_moves;

    // Credit and handshake terms.
    logic [CW-1:0] credit_sum;
    logic          credit_ok;
    logic          accept;
    logic          beat_in;
    logic          drain_done;

    assign accept  = read_q && !txm_waitrequest;
    // Beats that arrive while idle belong to an abandoned transfer.
    assign beat_in = txm_readdatavalid && (state_q != ST_IDLE);

    assign credit_sum = CW'(fifo_used) + CW'(outstanding_q);
    assign credit_ok  = (credit_sum <= CW'(DEPTH - BURST_BEATS));

    // The converter is empty when it sits on lane 0; with the FIFO also empty
    // the last word has already moved.
    assign drain_done = (outstanding_q == '0) && fifo_empty && (lane_q == 2'd0);

    // Beats still owed by the slave: +8 per accepted burst, -1 per beat.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept) begin
            outstanding_d = outstanding_d + OW'(BURST_BEATS);
        end
        if (beat_in && ((outstanding_q != '0) || accept)) begin
            outstanding_d = outstanding_d - OW'(1);
        end
    end

    // Main controller: request sequencing, address, burst count and status.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            read_q        <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            outstanding_q <= outstanding_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (num_bursts != 16'd0) begin
                            addr_q      <= base_addr;
                            remaining_q <= num_bursts;
                            busy_q      <= 1'b1;
                            state_q     <= ST_CHECK;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (credit_ok) begin
                        read_q  <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Address and read stay put until the slave takes the burst.
                    if (accept) begin
                        read_q      <= 1'b0;
                        addr_q      <= addr_q + AW'(BURST_BYTES);
                        remaining_q <= remaining_q - 16'd1;
                        state_q     <= (remaining_q == 16'd1) ? ST_DRAIN : ST_CHECK;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Converter lane pointer: advances on each transferred word and wraps
    // after lane 3, which is also when the head beat is popped.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            lane_q <= 2'd0;
        end else if (word_moves) begin
            lane_q <= lane_q + 2'd1;
        end
    end

    assign qv         = !fifo_empty;
    assign q          = lane_select(fifo_rdata, lane_q);
    assign word_moves = qv && q_ready;
    assign fifo_rd    = word_moves && (lane_q == 2'(LANES - 1));
    assign fifo_wr    = beat_in;

    sync_fifo_sa #(
        .W    (BEAT_W),
        .LOG2 (FLOG2)
    ) u_fifo (
        .clk     (c),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (txm_readdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .used    (fifo_used)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign txm_read       = read_q;
    assign txm_address    = addr_q;
    assign txm_burstcount = BURSTCOUNT;

endmodule
